seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It generalises the fixed 4-digit scanner to `NUM_DIGITS` digits and adds an internal refresh prescaler, per-digit blanking, per-digit blinking and 8-level PWM brightness. It sits between the UI/status registers (volume, octave, loop width, mode) and the board's anode/segment pins, and runs from the system clock rather than a pre-divided display clock.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned. Legal range is 1..8.
- `SCAN_DIV`, default 100000: clock cycles per digit slot. Must be a multiple of 8 and at least 8.
- `BLINK_FRAMES`, default 64: full scan frames per blink half-period. Must be at least 1.

Ports:
- `clk` input 1: system clock. This is the only clock.
- `rst` input 1: reset. Asynchronous, active-high.
- `digit_values` input 4*NUM_DIGITS: 4-bit code per digit. Digit i uses bits [4i+3:4i]. Digit 0 maps to the rightmost anode, DIGIT[0].
- `digit_enable` input NUM_DIGITS: 1 means the digit is shown; 0 means it is blanked.
- `blink_mask` input NUM_DIGITS: 1 means the digit blinks.
- `brightness` input 3: duty level 0..7. The on-time is (brightness+1)/8 of each slot.
- `DIGIT` output NUM_DIGITS: anodes, active-low, at most one low at any time.
- `DISPLAY` output 7: segments GFEDCBA, active-low.

## Operation
- Code decode (0 means segment lit, order GFEDCBA):
  - 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001
  - 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000
  - 4'hA = '-' = 011_1111
  - 4'hB..4'hF = blank = 111_1111
- State:
  - prescaler `p`, range 0..SCAN_DIV-1
  - scan index `idx`, range 0..NUM_DIGITS-1
  - frame counter `f`, range 0..BLINK_FRAMES-1
  - `blink_phase`, 1 bit
  - slot snapshot: segment code, on-flag, threshold `T`
- Terminal edge: any clock edge at which p==SCAN_DIV-1. At that edge, all of the following happen together:
  - p<=0.
  - idx<=(idx==NUM_DIGITS-1) ? 0 : idx+1, called n below.
  - If n==0 (frame wrap): f advances. When f==BLINK_FRAMES-1, f<=0 and blink_phase toggles.
  - Snapshot taken: seg<=decode(digit_values[n]).
  - on<=digit_enable[n] && !(blink_mask[n] && bp'), where bp' is the blink_phase value after this edge.
  - T<=(brightness+1)*(SCAN_DIV/8).
- Non-terminal edge: p<=p+1. All other state holds.
- Outputs are registered and updated on every edge from the post-edge state:
  - DIGIT[idx]=0 iff on && p<T. All other anodes are 1.
  - DISPLAY=seg while the anode is low, otherwise 111_1111.
- Inputs are sampled only at terminal edges. Changing inputs mid-slot has no effect until the next slot.
- NUM_DIGITS==1: idx stays 0 and every terminal edge is a frame wrap.

## Timing
- While rst is high, and immediately on its assertion:
  - DIGIT=all 1, DISPLAY=111_1111
  - p=SCAN_DIV-1, idx=NUM_DIGITS-1, f=BLINK_FRAMES-1, blink_phase=1, on=0
- First edge after rst deassertion:
  - This edge is a terminal edge with a frame wrap, so f<=0 and blink_phase<=0.
  - Digit 0 is loaded, and its outputs are valid immediately after that edge.
  - Latency from reset release to the first lit digit is 1 cycle.
- Each slot lasts exactly SCAN_DIV cycles.
- The anode is low for exactly T consecutive cycles, starting at the slot's first cycle.
- brightness=7 means the anode is low for the whole slot. There is no dark gap between slots.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- Blink half-period is BLINK_FRAMES frames. Phase 0 shows masked digits; phase 1 blanks them.
- Reset asserted mid-slot or mid-frame: outputs go dark asynchronously. Scanning restarts at digit 0, blink phase 0.

## Test plan
- Reset release, scan order. Params NUM_DIGITS=4, SCAN_DIV=8, BLINK_FRAMES=2. Inputs digit_values=16'h3210, all enabled, brightness=7.
  - Required: DIGIT steps 1110, 1101, 1011, 0111, 8 cycles each, starting 1 cycle after release.
  - Required: DISPLAY is 100_0000, 111_1001, 010_0100, 011_0000 in step.
- Brightness. Set brightness=1 with SCAN_DIV=8.
  - Required: each anode low for 2 cycles, then all 1 for 6 cycles.
  - Required: DISPLAY=111_1111 while dark.
  - Required: brightness=0 gives 1 low cycle per slot.
- Blanking and codes. Inputs digit_enable=4'b1011, values {A,F,9,8}.
  - Required: digit 2 anode never low.
  - Required: digit 3 shows 011_1111, digit 0 shows 000_0000, digit 1 shows 001_0000.
- Blink. Input blink_mask=4'b0001, BLINK_FRAMES=2.
  - Required: digit 0 lit in frames 0-1, dark in frames 2-3, lit again in frame 4.
  - Required: other digits lit in every frame.
- Mid-slot change and reset. Change digit_values during a digit-1 slot.
  - Required: DISPLAY unchanged until the next slot boundary.
  - Then assert rst mid-slot. Required: DIGIT=all 1 and DISPLAY=111_1111 without a clock edge.
  - After release, digit 0 is lit after 1 edge.
- NUM_DIGITS=1, SCAN_DIV=8, BLINK_FRAMES=1, blink_mask=1.
  - Required: DIGIT alternates between 0 for 8 cycles and 1 for 8 cycles.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit gets a slot of SCAN_DIV clocks. At the start of every slot the
// digit's code, visibility and PWM on-time are latched. The anode is then held
// low for the first T cycles of the slot. Digits can be blanked, blinked at a
// frame-based rate, or dimmed through eight brightness levels.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digit_values,
    input  logic [NUM_DIGITS-1:0]     digit_enable,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [2:0]                brightness,
    output logic [NUM_DIGITS-1:0]     DIGIT,
    output logic [6:0]                DISPLAY
);

    // The prescaler and threshold share one width, so a threshold equal to
    // SCAN_DIV (full brightness) still fits.
    localparam int TW = $clog2(SCAN_DIV) + 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TW-1:0] P_LAST   = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] SLICE    = TW'(SCAN_DIV / 8);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(BLINK_FRAMES - 1);

    logic [TW-1:0]         p, p_next;
    logic [IW-1:0]         idx, idx_next;
    logic [FW-1:0]         f, f_next;
    logic                  blink_phase, blink_phase_next;
    logic [6:0]            seg, seg_next;
    logic                  on, on_next;
    logic [TW-1:0]         thr, thr_next;
    logic [NUM_DIGITS-1:0] digit_next;
    logic [6:0]            display_next;

    // Segment patterns, active-low, bit order GFEDCBA.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'h0:    pattern = 7'b100_0000;
            4'h1:    pattern = 7'b111_1001;
            4'h2:    pattern = 7'b010_0100;
            4'h3:    pattern = 7'b011_0000;
            4'h4:    pattern = 7'b001_1001;
            4'h5:    pattern = 7'b001_0010;
            4'h6:    pattern = 7'b000_0010;
            4'h7:    pattern = 7'b111_1000;
            4'h8:    pattern = 7'b000_0000;
            4'h9:    pattern = 7'b001_0000;
            4'hA:    pattern = 7'b011_1111;
            default: pattern = 7'b111_1111;
        endcase
        return pattern;
    endfunction

    // Next-state logic: count within the slot, and at the terminal count move
    // to the next digit and latch its snapshot. Outputs come from the
    // post-edge state, so a new slot is visible right after its first edge.
    always_comb begin
        p_next           = p + 1'b1;
        idx_next         = idx;
        f_next           = f;
        blink_phase_next = blink_phase;
        seg_next         = seg;
        on_next          = on;
        thr_next         = thr;
        digit_next       = '1;
        display_next     = 7'b111_1111;

        if (p == P_LAST) begin
            p_next   = '0;
            idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (idx_next == '0) begin
                if (f == F_LAST) begin
                    f_next           = '0;
                    blink_phase_next = ~blink_phase;
                end else begin
                    f_next = f + 1'b1;
                end
            end
            seg_next = decode(digit_values[{idx_next, 2'b00} +: 4]);
            on_next  = digit_enable[idx_next] &&
                       !(blink_mask[idx_next] && blink_phase_next);
            thr_next = (TW'(brightness) + TW'(1)) * SLICE;
        end

        if (on_next && (p_next < thr_next)) begin
            digit_next[idx_next] = 1'b0;
            display_next         = seg_next;
        end
    end

    // State and output registers; reset parks the scanner on the last slot of
    // the last frame in phase 1, so the first edge wraps to digit 0, phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p           <= P_LAST;
            idx         <= IDX_LAST;
            f           <= F_LAST;
            blink_phase <= 1'b1;
            seg         <= 7'b111_1111;
            on          <= 1'b0;
            thr         <= '0;
            DIGIT       <= '1;
            DISPLAY     <= 7'b111_1111;
        end else begin
            p           <= p_next;
            idx         <= idx_next;
            f           <= f_next;
            blink_phase <= blink_phase_next;
            seg         <= seg_next;
            on          <= on_next;
            thr         <= thr_next;
            DIGIT       <= digit_next;
            DISPLAY     <= display_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
// Directed bench for the scanner: a 4-digit instance with an 8-cycle slot and
// 2-frame blink, plus a 1-digit instance with a 1-frame blink.
module tb_seven_segment_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] digit_values;
    logic [3:0]  digit_enable;
    logic [3:0]  blink_mask;
    logic [2:0]  brightness;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;

    logic        rst1;
    logic [3:0]  digit_values1;
    logic        digit_enable1;
    logic        blink_mask1;
    logic [2:0]  brightness1;
    logic        DIGIT1;
    logic [6:0]  DISPLAY1;

    int tests_run    = 0;
    int tests_failed = 0;

    seven_segment_scanner #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .BLINK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_values(digit_values),
        .digit_enable(digit_enable),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .DIGIT       (DIGIT),
        .DISPLAY     (DISPLAY)
    );

    seven_segment_scanner #(
        .NUM_DIGITS  (1),
        .SCAN_DIV    (8),
        .BLINK_FRAMES(1)
    ) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .digit_values(digit_values1),
        .digit_enable(digit_enable1),
        .blink_mask  (blink_mask1),
        .brightness  (brightness1),
        .DIGIT       (DIGIT1),
        .DISPLAY     (DISPLAY1)
    );

    // Free-running system clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [15:0] values, input logic [3:0] enable,
                                 input logic [3:0] mask, input logic [2:0] level);
        digit_values = values;
        digit_enable = enable;
        blink_mask   = mask;
        brightness   = level;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full slot sampled on falling edges: anode low and segments shown for
    // the first 'lit' cycles, dark afterwards.
    task automatic checkSlot(input string tag, input logic [3:0] exp_digit,
                             input logic [6:0] exp_seg, input int lit);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s c%0d DIGIT", tag, c), {4'h0, DIGIT},
                        {4'h0, (c < lit) ? exp_digit : 4'hF});
            checkOutput($sformatf("%s c%0d DISPLAY", tag, c), {1'b0, DISPLAY},
                        {1'b0, (c < lit) ? exp_seg : 7'h7F});
        end
    endtask

    initial begin
        rst  = 1'b1;
        rst1 = 1'b1;
        applyStimulus(16'h3210, 4'hF, 4'h0, 3'd7);
        digit_values1 = 4'h5;
        digit_enable1 = 1'b1;
        blink_mask1   = 1'b1;
        brightness1   = 3'd7;

        repeat (3) @(negedge clk);
        checkOutput("reset DIGIT", {4'h0, DIGIT}, 8'h0F);
        checkOutput("reset DISPLAY", {1'b0, DISPLAY}, 8'h7F);
        checkOutput("reset1 DIGIT", {7'h0, DIGIT1}, 8'h01);
        checkOutput("reset1 DISPLAY", {1'b0, DISPLAY1}, 8'h7F);

        // Frame 0: scan order at full brightness.
        rst = 1'b0;
        checkSlot("scan d0", 4'b1110, 7'h40, 8);
        checkSlot("scan d1", 4'b1101, 7'h79, 8);
        checkSlot("scan d2", 4'b1011, 7'h24, 8);
        checkSlot("scan d3", 4'b0111, 7'h30, 8);

        // Frame 1: brightness 1 then 0.
        applyStimulus(16'h3210, 4'hF, 4'h0, 3'd1);
        checkSlot("bright1 d0", 4'b1110, 7'h40, 2);
        checkSlot("bright1 d1", 4'b1101, 7'h79, 2);
        applyStimulus(16'h3210, 4'hF, 4'h0, 3'd0);
        checkSlot("bright0 d2", 4'b1011, 7'h24, 1);
        checkSlot("bright0 d3", 4'b0111, 7'h30, 1);

        // Frame 2: blanking and special codes.
        applyStimulus(16'hAF98, 4'b1011, 4'h0, 3'd7);
        checkSlot("codes d0", 4'b1110, 7'h00, 8);
        checkSlot("codes d1", 4'b1101, 7'h10, 8);
        checkSlot("blank d2", 4'b1011, 7'h7F, 0);
        checkSlot("codes d3", 4'b0111, 7'h3F, 8);

        // Frame 3: inputs change mid-slot, then reset mid-slot.
        checkSlot("mid d0", 4'b1110, 7'h00, 8);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mid d1 c%0d DIGIT", c), {4'h0, DIGIT}, 8'h0D);
            checkOutput($sformatf("mid d1 c%0d DISPLAY", c), {1'b0, DISPLAY}, 8'h10);
            if (c == 2) applyStimulus(16'h0000, 4'hF, 4'h0, 3'd7);
        end
        checkSlot("mid d2", 4'b1011, 7'h40, 8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mid d3 c%0d DIGIT", c), {4'h0, DIGIT}, 8'h07);
            checkOutput($sformatf("mid d3 c%0d DISPLAY", c), {1'b0, DISPLAY}, 8'h40);
        end
        rst = 1'b1;
        #1;
        checkOutput("async rst DIGIT", {4'h0, DIGIT}, 8'h0F);
        checkOutput("async rst DISPLAY", {1'b0, DISPLAY}, 8'h7F);
        @(negedge clk);
        checkOutput("held rst DIGIT", {4'h0, DIGIT}, 8'h0F);
        checkOutput("held rst DISPLAY", {1'b0, DISPLAY}, 8'h7F);

        // Blink: digit 0 masked, visible in frames 0-1 and 4, dark in 2-3.
        applyStimulus(16'h3210, 4'hF, 4'b0001, 3'd7);
        rst = 1'b0;
        for (int fr = 0; fr < 5; fr++) begin
            checkSlot($sformatf("blink f%0d d0", fr), 4'b1110, 7'h40,
                      (fr == 2 || fr == 3) ? 0 : 8);
            checkSlot($sformatf("blink f%0d d1", fr), 4'b1101, 7'h79, 8);
            checkSlot($sformatf("blink f%0d d2", fr), 4'b1011, 7'h24, 8);
            checkSlot($sformatf("blink f%0d d3", fr), 4'b0111, 7'h30, 8);
        end

        // Single-digit instance: blinks every frame, 8 cycles on, 8 off.
        rst1 = 1'b0;
        for (int fr = 0; fr < 4; fr++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                checkOutput($sformatf("single f%0d c%0d DIGIT", fr, c), {7'h0, DIGIT1},
                            (fr % 2 == 0) ? 8'h00 : 8'h01);
                checkOutput($sformatf("single f%0d c%0d DISPLAY", fr, c), {1'b0, DISPLAY1},
                            (fr % 2 == 0) ? 8'h12 : 8'h7F);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
